// File: rtl/count_rate_ctrl.sv
// count_rate_ctrl
//   Run/pause/stop controller and tick scheduler for the feature counter.
//   Produces a one-cycle, registered count enable (tick) every P clk cycles
//   while running, where P = TICK_HALF << active_rate. Rate changes requested
//   while running are held pending and take effect on a tick boundary, so no
//   period is ever truncated.
//
//   Optional feature macro: TICK_LIMIT_EN (adds tick_limit / done ports and
//   stops the run automatically after tick_limit ticks).
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous active-high reset
//   start_i      in   1   pulse: IDLE -> RUN
//   pause_i      in   1   pulse: toggle RUN <-> PAUSE
//   stop_i       in   1   pulse: any state -> IDLE
//   rate_sel     in   2   requested rate (0=0.5 s, 1=1 s, 2=2 s, 3=4 s)
//   rate_load    in   1   pulse: capture rate_sel
//   tick_limit   in  16   tick count limit, 0 = unlimited (TICK_LIMIT_EN only)
//   tick         out  1   one-cycle count enable
//   running      out  1   state is RUN
//   paused       out  1   state is PAUSE
//   active_rate  out  2   rate currently timing the prescaler
//   rate_pending out  1   captured rate waiting for the next tick boundary
//   done         out  1   pulses one cycle after the final tick (TICK_LIMIT_EN only)

module count_rate_ctrl #(
  parameter int unsigned TICK_HALF = 25_000_000,
  parameter int unsigned CNT_W     = 28,
  parameter logic [1:0]  RATE_RST  = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic       stop_i,
  input  logic [1:0] rate_sel,
  input  logic       rate_load,
`ifdef TICK_LIMIT_EN
  input  logic [15:0] tick_limit,
  output logic        done,
`endif
  output logic       tick,
  output logic       running,
  output logic       paused,
  output logic [1:0] active_rate,
  output logic       rate_pending
);

  localparam longint unsigned MaxPeriod = 64'(TICK_HALF) << 3;
  localparam longint unsigned CountSpan = 64'd1 << CNT_W;

  if (MaxPeriod > CountSpan) begin : gBadCfg
    $error("count_rate_ctrl: TICK_HALF << 3 exceeds 2**CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CNT_W-1:0] prescaler;
  logic [CNT_W:0]   period;
  logic [CNT_W-1:0] lastCount;
  logic             terminal;
  logic             fireTick;
  logic             limitHit;
  logic [1:0]       pendRate;

  // One extra bit so a period of exactly 2**CNT_W is still representable.
  assign period    = (CNT_W + 1)'(TICK_HALF) << active_rate;
  assign lastCount = CNT_W'(period - {{CNT_W{1'b0}}, 1'b1});
  assign terminal  = (state == RUN) && (prescaler == lastCount);

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);

`ifdef TICK_LIMIT_EN
  logic [15:0] tickCount;
  logic        finalTick;

  assign limitHit = (tick_limit != '0) &&
                    (({1'b0, tickCount} + 17'd1) >= {1'b0, tick_limit});
`else
  assign limitHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Priority stop > pause > start; a stop or pause in the terminal cycle
  // swallows that period's tick.
  always_comb begin
    nextState = state;
    fireTick  = 1'b0;
    case (state)
      IDLE: begin
        if (!stop_i && start_i) nextState = RUN;
      end
      RUN: begin
        if (stop_i) begin
          nextState = IDLE;
        end else if (pause_i) begin
          nextState = PAUSE;
        end else if (terminal) begin
          fireTick = 1'b1;
          if (limitHit) nextState = IDLE;
        end
      end
      PAUSE: begin
        if (stop_i) begin
          nextState = IDLE;
        end else if (pause_i) begin
          nextState = RUN;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler    <= '0;
      tick         <= 1'b0;
      active_rate  <= RATE_RST;
      pendRate     <= RATE_RST;
      rate_pending <= 1'b0;
    end else begin
      tick <= fireTick;

      // Prescaler only advances across RUN->RUN; entering PAUSE freezes it
      // without counting the pause cycle, so resume continues the same period.
      if (nextState == IDLE) begin
        prescaler <= '0;
      end else if ((state == RUN) && (nextState == RUN)) begin
        prescaler <= fireTick ? '0 : prescaler + CNT_W'(1);
      end

      if (rate_load) begin
        if ((state != RUN) || stop_i || fireTick) begin
          active_rate  <= rate_sel;
          rate_pending <= 1'b0;
        end else begin
          pendRate     <= rate_sel;
          rate_pending <= 1'b1;
        end
      end else if (rate_pending && (fireTick || stop_i)) begin
        active_rate  <= pendRate;
        rate_pending <= 1'b0;
      end
    end
  end

`ifdef TICK_LIMIT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tickCount <= '0;
      finalTick <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (stop_i || ((state == IDLE) && start_i)) begin
        tickCount <= '0;
      end else if (fireTick) begin
        tickCount <= tickCount + 16'd1;
      end
      // finalTick is high alongside the last tick; done follows one cycle later.
      finalTick <= fireTick && limitHit;
      done      <= finalTick;
    end
  end
`endif

endmodule

// File: tb/tb_count_rate_ctrl.sv
module tb_count_rate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       stop_i = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic       rate_load = 1'b0;
  logic       tick;
  logic       running;
  logic       paused;
  logic [1:0] active_rate;
  logic       rate_pending;
`ifdef TICK_LIMIT_EN
  logic [15:0] tick_limit = 16'd0;
  logic        done;
`endif

  count_rate_ctrl #(
    .TICK_HALF(4),
    .CNT_W(8),
    .RATE_RST(2'b01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_i(start_i),
    .pause_i(pause_i),
    .stop_i(stop_i),
    .rate_sel(rate_sel),
    .rate_load(rate_load),
`ifdef TICK_LIMIT_EN
    .tick_limit(tick_limit),
    .done(done),
`endif
    .tick(tick),
    .running(running),
    .paused(paused),
    .active_rate(active_rate),
    .rate_pending(rate_pending)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic       st;
    logic       pa;
    logic       sp;
    logic       ld;
    logic [1:0] sel;
    logic [5:0] exp;  // {tick, running, paused, active_rate, rate_pending}
  } vecT;

  vecT        vecs[28];
  logic [5:0] sb[$];

  function automatic vecT mk(input logic st, pa, sp, ld, input logic [1:0] sel,
                             input logic t, r, p, input logic [1:0] rate, input logic pend);
    vecT v;
    v.st = st; v.pa = pa; v.sp = sp; v.ld = ld; v.sel = sel;
    v.exp = {t, r, p, rate, pend};
    return v;
  endfunction

  function automatic logic [5:0] obs();
    return {tick, running, paused, active_rate, rate_pending};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic st, pa, sp, ld, input logic [1:0] sel);
    start_i = st; pause_i = pa; stop_i = sp; rate_load = ld; rate_sel = sel;
    @(posedge clk); #1;
    start_i = 1'b0; pause_i = 1'b0; stop_i = 1'b0; rate_load = 1'b0;
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // P = 4 once rate 0 is loaded; expectation is the output after the edge.
    vecs[0]  = mk(0,0,0,1,2'd0, 0,0,0,2'd0,0);
    vecs[1]  = mk(1,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[2]  = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[3]  = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[4]  = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[5]  = mk(0,0,0,0,2'd0, 1,1,0,2'd0,0);
    vecs[6]  = mk(0,0,0,1,2'd2, 0,1,0,2'd0,1);
    vecs[7]  = mk(0,0,0,0,2'd0, 0,1,0,2'd0,1);
    vecs[8]  = mk(0,0,0,0,2'd0, 0,1,0,2'd0,1);
    vecs[9]  = mk(0,0,0,0,2'd0, 1,1,0,2'd2,0);
    vecs[10] = mk(0,1,0,0,2'd0, 0,0,1,2'd2,0);
    vecs[11] = mk(1,0,0,0,2'd0, 0,0,1,2'd2,0);
    vecs[12] = mk(0,0,0,1,2'd0, 0,0,1,2'd0,0);
    vecs[13] = mk(0,1,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[14] = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[15] = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[16] = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[17] = mk(0,1,0,0,2'd0, 0,0,1,2'd0,0);
    vecs[18] = mk(0,1,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[19] = mk(0,0,0,0,2'd0, 1,1,0,2'd0,0);
    vecs[20] = mk(0,1,1,0,2'd0, 0,0,0,2'd0,0);
    vecs[21] = mk(1,0,1,0,2'd0, 0,0,0,2'd0,0);
    vecs[22] = mk(0,1,0,0,2'd0, 0,0,0,2'd0,0);
    vecs[23] = mk(1,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[24] = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[25] = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[26] = mk(0,0,0,0,2'd0, 0,1,0,2'd0,0);
    vecs[27] = mk(0,0,0,1'b0,2'd0, 0,0,0,2'd0,0);
    vecs[27].sp = 1'b1;  // stop on the terminal cycle

    doReset();
    chk("reset", 32'(obs()), 32'(6'b000010));

    // Table vectors through the scoreboard queue.
    foreach (vecs[i]) begin
      sb.push_back(vecs[i].exp);
      step(vecs[i].st, vecs[i].pa, vecs[i].sp, vecs[i].ld, vecs[i].sel);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(sb.pop_front()));
    end

    // Start latency and steady tick spacing at P = 8.
    doReset();
    step(1, 0, 0, 0, 2'd0);
    chk("runLatency", 32'(running), 32'd1);
    while (cyc <= 26) begin
      chk("tickA", 32'(tick), 32'((cyc == 9) || (cyc == 17) || (cyc == 25)));
      idle();
    end

    // Rate load mid-run deferred to the tick at 17.
    doReset();
    step(1, 0, 0, 0, 2'd0);
    while (cyc < 10) idle();
    step(0, 0, 0, 1, 2'd0);
    chk("pendB", 32'({active_rate, rate_pending}), 32'({2'd1, 1'b1}));
    while (cyc <= 22) begin
      if (cyc >= 12) chk("tickB", 32'(tick), 32'((cyc == 17) || (cyc == 21)));
      if (cyc == 17) chk("applyB", 32'({active_rate, rate_pending}), 32'({2'd0, 1'b0}));
      idle();
    end

    // Pause mid-period, hold 20 cycles, resume and finish the same period.
    doReset();
    step(1, 0, 0, 0, 2'd0);
    while (cyc < 12) idle();
    step(0, 1, 0, 0, 2'd0);
    chk("pausedC", 32'({running, paused}), 32'({1'b0, 1'b1}));
    for (int k = 0; k < 20; k++) begin
      idle();
      chk("holdC", 32'({tick, paused}), 32'({1'b0, 1'b1}));
    end
    step(0, 1, 0, 0, 2'd0);
    for (int k = 1; k <= 6; k++) begin
      chk("resumeC", 32'({tick, running}), 32'({(k == 6), 1'b1}));
      if (k < 6) idle();
    end

    // Stop applies a pending rate; reset mid-period clears everything.
    doReset();
    step(1, 0, 0, 0, 2'd0);
    while (cyc < 4) idle();
    step(0, 0, 0, 1, 2'd3);
    chk("pendD", 32'({active_rate, rate_pending}), 32'({2'd1, 1'b1}));
    step(0, 0, 1, 0, 2'd0);
    chk("stopD", 32'(obs()), 32'(6'b000110));
    step(1, 0, 0, 0, 2'd0);
    repeat (3) idle();
    step(0, 0, 0, 1, 2'd0);
    chk("pendD2", 32'(obs()), 32'(6'b010111));
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rstD", 32'(obs()), 32'(6'b000010));

`ifdef TICK_LIMIT_EN
    begin
      int unsigned nTicks;
      nTicks = 0;
      doReset();
      tick_limit = 16'd3;
      step(1, 0, 0, 0, 2'd0);
      while (cyc <= 40) begin
        if (tick) nTicks++;
        chk("doneE", 32'(done), 32'(cyc == 26));
        if (cyc == 25) chk("lastE", 32'({tick, running}), 32'({1'b1, 1'b0}));
        idle();
      end
      chk("countE", nTicks, 32'd3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
